harmonic_sequencer: RTL and testbench

//  Per-sample scheduler for the additive-synthesis datapath: on each sample tick, walks harmonics 0..N-1.
//  For each harmonic it reads/advances/writes its phase in the sample-position RAM, addresses the sine LUT,
//  and hands each LUT value to the scaling accumulator with a per-harmonic amplitude. Sits between the
//  ADC control registers (frequency, harmonic count, roll-off) and the RAM/LUT/accumulator/DAC path.

---
 rtl/synth_pkg.sv | 42 ++++
 rtl/harmonic_phase_step.sv | 25 ++
 rtl/harmonic_sequencer.sv | 273 +++++++++++++++++++++++++++
 tb/tb_harmonic_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared constants, state encoding and helpers for the additive-synthesis
// harmonic sequencer.
package synth_pkg;

  localparam int SAMPLERATE = 48000;
  localparam int LUT_SHIFT  = 5;
  localparam int MAX_HARM   = 64;
  localparam int DIV_BIT    = 7;
  localparam int PHASE_W    = 16;
  localparam int FH_W       = 24;
  localparam int LUT_W      = 11;

  // Typed forms of the constants so comparisons stay width-matched.
  localparam logic [PHASE_W-1:0] SR_PHASE     = 16'd48000;
  localparam logic [PHASE_W-1:0] SR_PHASE_MAX = 16'd47999;
  localparam logic [7:0]         MAX_HARM_C   = 8'd64;
  localparam logic [FH_W-1:0]    NYQ_FH       = 24'd24000;
  localparam logic [DIV_BIT-1:0] MULT_FULL    = {DIV_BIT{1'b1}};

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LOAD  = 4'd1,
    ST_READ  = 4'd2,
    ST_STEP  = 4'd3,
    ST_WRITE = 4'd4,
    ST_LUTW  = 4'd5,
    ST_ISSUE = 4'd6,
    ST_DRAIN = 4'd7,
    ST_DONE  = 4'd8
  } state_t;

  // Amplitude step down that stops at zero instead of wrapping.
  function automatic logic [DIV_BIT-1:0] sat0_sub(input logic [DIV_BIT-1:0] a,
                                                  input logic [DIV_BIT-1:0] b);
    if (a > b) begin
      return a - b;
    end else begin
      return {DIV_BIT{1'b0}};
    end
  endfunction

endpackage

// File: rtl/harmonic_phase_step.sv
// Combinational modular add: (a + b) mod SAMPLERATE, valid for a, b < SAMPLERATE,
// so a single conditional subtract is enough.
module harmonic_phase_step
  import synth_pkg::*;
(
  input  logic [PHASE_W-1:0] a,
  input  logic [PHASE_W-1:0] b,
  output logic [PHASE_W-1:0] sum
);

  logic [PHASE_W:0] raw_s;
  logic [PHASE_W:0] wrap_s;

  // 17-bit sum, then fold back once if it crossed the modulus.
  always_comb begin
    raw_s  = {1'b0, a} + {1'b0, b};
    wrap_s = raw_s - {1'b0, SR_PHASE};
    if (raw_s >= {1'b0, SR_PHASE}) begin
      sum = wrap_s[PHASE_W-1:0];
    end else begin
      sum = raw_s[PHASE_W-1:0];
    end
  end

endmodule

// File: rtl/harmonic_sequencer.sv
// Per-sample harmonic scheduler: walks harmonics 0..count-1 on each sample
// tick, advancing each phase in the phase RAM, addressing the sine LUT and
// issuing the LUT value to the scaling accumulator with a falling amplitude.
// Optional build macro NYQUIST_CUTOFF_EN: the frame ends at the first harmonic
// whose unreduced frequency reaches SAMPLERATE/2.
module harmonic_sequencer
  import synth_pkg::*;
(
  input  logic               fpga_clock,
  input  logic               reset,
  input  logic               sample_tick,
  input  logic [15:0]        frequency,
  input  logic [7:0]         harmonic_count,
  input  logic [DIV_BIT-1:0] rolloff,
  output logic [7:0]         pr_addr,
  output logic               pr_we,
  output logic [15:0]        pr_wdata,
  input  logic [15:0]        pr_rdata,
  output logic [10:0]        lut_addr,
  output logic               adder_clear,
  output logic               adder_start,
  output logic [DIV_BIT-1:0] adder_mult,
  input  logic               adder_ready,
  output logic               frame_done,
  output logic               busy,
  output logic               overrun
);

  state_t state_r, state_s;
  logic [PHASE_W-1:0] freq_r, freq_s;
  logic [PHASE_W-1:0] inc_r, inc_s;
  logic [7:0]         count_r, count_s;
  logic [7:0]         h_r, h_s, h_next_s;
  logic [DIV_BIT-1:0] rolloff_r, rolloff_s;
  logic [DIV_BIT-1:0] mult_r, mult_s;
  logic               lut_wait_r, lut_wait_s;
`ifdef NYQUIST_CUTOFF_EN
  logic [FH_W-1:0]    fh_r, fh_s, fh_next_s;
`endif

  logic [7:0]         pr_addr_r, pr_addr_s;
  logic               pr_we_r, pr_we_s;
  logic [15:0]        pr_wdata_r, pr_wdata_s;
  logic [10:0]        lut_addr_r, lut_addr_s;
  logic               adder_clear_r, adder_clear_s;
  logic               adder_start_r, adder_start_s;
  logic [DIV_BIT-1:0] adder_mult_r, adder_mult_s;
  logic               frame_done_r, frame_done_s;
  logic               busy_r, busy_s;

  logic [PHASE_W-1:0] freq_clamp_s;
  logic [7:0]         count_clamp_s;
  logic [PHASE_W-1:0] phase_sum_s;
  logic [PHASE_W-1:0] inc_sum_s;

  // New phase of the current harmonic from the value just read back.
  harmonic_phase_step u_phase_step (
    .a   (pr_rdata),
    .b   (inc_r),
    .sum (phase_sum_s)
  );

  // Phase increment of the next harmonic: (h+2)*freq reduced.
  harmonic_phase_step u_inc_step (
    .a   (inc_r),
    .b   (freq_r),
    .sum (inc_sum_s)
  );

  // Clamp the control-register inputs to their legal ranges.
  always_comb begin
    if (frequency >= SR_PHASE) begin
      freq_clamp_s = SR_PHASE_MAX;
    end else begin
      freq_clamp_s = frequency;
    end
    if (harmonic_count > MAX_HARM_C) begin
      count_clamp_s = MAX_HARM_C;
    end else begin
      count_clamp_s = harmonic_count;
    end
  end

  // Next-state and next-output decode; outputs are registered on entry to the state they belong to.
  always_comb begin
    state_s       = state_r;
    freq_s        = freq_r;
    inc_s         = inc_r;
    count_s       = count_r;
    h_s           = h_r;
    h_next_s      = h_r + 8'd1;
    rolloff_s     = rolloff_r;
    mult_s        = mult_r;
    lut_wait_s    = lut_wait_r;
`ifdef NYQUIST_CUTOFF_EN
    fh_s          = fh_r;
    fh_next_s     = fh_r + {8'd0, freq_r};
`endif
    pr_addr_s     = pr_addr_r;
    pr_we_s       = 1'b0;
    pr_wdata_s    = pr_wdata_r;
    lut_addr_s    = lut_addr_r;
    adder_clear_s = 1'b0;
    adder_start_s = 1'b0;
    adder_mult_s  = adder_mult_r;
    frame_done_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (sample_tick) begin
          state_s       = ST_LOAD;
          adder_clear_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        freq_s    = freq_clamp_s;
        count_s   = count_clamp_s;
        rolloff_s = rolloff;
        inc_s     = freq_clamp_s;
        h_s       = 8'd0;
        mult_s    = MULT_FULL;
`ifdef NYQUIST_CUTOFF_EN
        fh_s      = {8'd0, freq_clamp_s};
`endif
        if (count_clamp_s == 8'd0) begin
          state_s      = ST_DONE;
          frame_done_s = 1'b1;
        end
`ifdef NYQUIST_CUTOFF_EN
        else if ({8'd0, freq_clamp_s} >= NYQ_FH) begin
          state_s = ST_DRAIN;
        end
`endif
        else begin
          state_s   = ST_READ;
          pr_addr_s = 8'd0;
        end
      end
      ST_READ: begin
        state_s = ST_STEP;
      end
      ST_STEP: begin
        state_s    = ST_WRITE;
        pr_we_s    = 1'b1;
        pr_wdata_s = phase_sum_s;
        lut_addr_s = phase_sum_s[LUT_SHIFT +: LUT_W];
      end
      ST_WRITE: begin
        state_s    = ST_LUTW;
        lut_wait_s = 1'b0;
      end
      ST_LUTW: begin
        if (!lut_wait_r) begin
          lut_wait_s = 1'b1;
          inc_s      = inc_sum_s;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (adder_ready) begin
          adder_start_s = 1'b1;
          adder_mult_s  = mult_r;
          mult_s        = sat0_sub(mult_r, rolloff_r);
          h_s           = h_next_s;
`ifdef NYQUIST_CUTOFF_EN
          fh_s          = fh_next_s;
`endif
          if (h_next_s == count_r) begin
            state_s = ST_DRAIN;
          end
`ifdef NYQUIST_CUTOFF_EN
          else if (fh_next_s >= NYQ_FH) begin
            state_s = ST_DRAIN;
          end
`endif
          else begin
            state_s   = ST_READ;
            pr_addr_s = h_next_s;
          end
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        // Skip the cycle the start pulse is still on the wire, so a slow ready drop is not missed.
        if (adder_ready && !adder_start_r) begin
          state_s      = ST_DONE;
          frame_done_s = 1'b1;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // Sequencer state and per-frame working registers.
  always_ff @(posedge fpga_clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      freq_r     <= 16'd0;
      inc_r      <= 16'd0;
      count_r    <= 8'd0;
      h_r        <= 8'd0;
      rolloff_r  <= {DIV_BIT{1'b0}};
      mult_r     <= {DIV_BIT{1'b0}};
      lut_wait_r <= 1'b0;
`ifdef NYQUIST_CUTOFF_EN
      fh_r       <= 24'd0;
`endif
    end else begin
      state_r    <= state_s;
      freq_r     <= freq_s;
      inc_r      <= inc_s;
      count_r    <= count_s;
      h_r        <= h_s;
      rolloff_r  <= rolloff_s;
      mult_r     <= mult_s;
      lut_wait_r <= lut_wait_s;
`ifdef NYQUIST_CUTOFF_EN
      fh_r       <= fh_s;
`endif
    end
  end

  // Output registers.
  always_ff @(posedge fpga_clock or posedge reset) begin
    if (reset) begin
      pr_addr_r     <= 8'd0;
      pr_we_r       <= 1'b0;
      pr_wdata_r    <= 16'd0;
      lut_addr_r    <= 11'd0;
      adder_clear_r <= 1'b0;
      adder_start_r <= 1'b0;
      adder_mult_r  <= {DIV_BIT{1'b0}};
      frame_done_r  <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      pr_addr_r     <= pr_addr_s;
      pr_we_r       <= pr_we_s;
      pr_wdata_r    <= pr_wdata_s;
      lut_addr_r    <= lut_addr_s;
      adder_clear_r <= adder_clear_s;
      adder_start_r <= adder_start_s;
      adder_mult_r  <= adder_mult_s;
      frame_done_r  <= frame_done_s;
      busy_r        <= busy_s;
    end
  end

  assign pr_addr     = pr_addr_r;
  assign pr_we       = pr_we_r;
  assign pr_wdata    = pr_wdata_r;
  assign lut_addr    = lut_addr_r;
  assign adder_clear = adder_clear_r;
  assign adder_start = adder_start_r;
  assign adder_mult  = adder_mult_r;
  assign frame_done  = frame_done_r;
  assign busy        = busy_r;
  // Overrun must flag the very cycle the rejected tick arrives, so it is decoded from the busy register.
  assign overrun     = sample_tick & busy_r;

endmodule

// File: tb/tb_harmonic_sequencer.sv
// Directed self-checking bench for harmonic_sequencer with a phase-RAM model
// and pulse monitors. Expectations for the Nyquist cases follow NYQUIST_CUTOFF_EN.
module tb_harmonic_sequencer;

  logic        fpga_clock = 1'b0;
  logic        reset;
  logic        sample_tick;
  logic [15:0] frequency;
  logic [7:0]  harmonic_count;
  logic [6:0]  rolloff;
  logic [7:0]  pr_addr;
  logic        pr_we;
  logic [15:0] pr_wdata;
  logic [15:0] pr_rdata;
  logic [10:0] lut_addr;
  logic        adder_clear;
  logic        adder_start;
  logic [6:0]  adder_mult;
  logic        adder_ready;
  logic        frame_done;
  logic        busy;
  logic        overrun;

  harmonic_sequencer dut (
    .fpga_clock     (fpga_clock),
    .reset          (reset),
    .sample_tick    (sample_tick),
    .frequency      (frequency),
    .harmonic_count (harmonic_count),
    .rolloff        (rolloff),
    .pr_addr        (pr_addr),
    .pr_we          (pr_we),
    .pr_wdata       (pr_wdata),
    .pr_rdata       (pr_rdata),
    .lut_addr       (lut_addr),
    .adder_clear    (adder_clear),
    .adder_start    (adder_start),
    .adder_mult     (adder_mult),
    .adder_ready    (adder_ready),
    .frame_done     (frame_done),
    .busy           (busy),
    .overrun        (overrun)
  );

  always #5 fpga_clock = ~fpga_clock;

  // Phase RAM model with a bench-side preload port.
  logic [15:0] mem [0:255];
  logic        pre_en;
  logic [7:0]  pre_addr;
  logic [15:0] pre_data;

  always @(posedge fpga_clock) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (pr_we) mem[pr_addr] <= pr_wdata;
    pr_rdata <= mem[pr_addr];
  end

  // Pulse monitors, sampled on the falling edge.
  int we_cnt = 0, st_cnt = 0, fd_cnt = 0, clr_cnt = 0, ov_cnt = 0;
  logic [7:0]  we_addr_q [0:511];
  logic [15:0] we_data_q [0:511];
  logic [10:0] we_lut_q  [0:511];
  logic [6:0]  st_mult_q [0:511];

  always @(negedge fpga_clock) begin
    if (pr_we) begin
      we_addr_q[we_cnt] <= pr_addr;
      we_data_q[we_cnt] <= pr_wdata;
      we_lut_q[we_cnt]  <= lut_addr;
      we_cnt <= we_cnt + 1;
    end
    if (adder_start) begin
      st_mult_q[st_cnt] <= adder_mult;
      st_cnt <= st_cnt + 1;
    end
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (adder_clear) clr_cnt <= clr_cnt + 1;
    if (overrun) ov_cnt <= ov_cnt + 1;
  end

  int checks = 0;
  int failures = 0;
  int b_we, b_st, b_fd, b_clr, b_ov;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge fpga_clock);
      #1;
    end
  endtask

  task automatic set_mem(input logic [7:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en = 1'b1;
    cyc(1);
    pre_en = 1'b0;
  endtask

  task automatic snap;
    b_we = we_cnt;
    b_st = st_cnt;
    b_fd = fd_cnt;
    b_clr = clr_cnt;
    b_ov = ov_cnt;
  endtask

  task automatic tick_pulse;
    sample_tick = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!frame_done && n < 2000) begin
      cyc(1);
      n++;
    end
    check(tag, frame_done, 1);
    cyc(2);
  endtask

  task automatic run_frame(input logic [15:0] f, input logic [7:0] c, input logic [6:0] r, input string tag);
    frequency = f;
    harmonic_count = c;
    rolloff = r;
    snap();
    tick_pulse();
    wait_done(tag);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    sample_tick = 1'b0;
    frequency = 16'd0;
    harmonic_count = 8'd0;
    rolloff = 7'd0;
    adder_ready = 1'b1;
    pre_en = 1'b0;
    pre_addr = 8'd0;
    pre_data = 16'd0;
    cyc(3);

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_pr_addr", pr_addr, 0);
    check("rst_mult", adder_mult, 0);
    check("rst_outs", {pr_we, adder_start, adder_clear, frame_done, overrun}, 0);
    reset = 1'b0;
    cyc(1);

    // 1: single harmonic with phase wrap
    set_mem(8'd0, 16'd47500);
    run_frame(16'd1000, 8'd1, 7'd0, "t1_done");
    check("t1_we_cnt", we_cnt - b_we, 1);
    check("t1_wdata", we_data_q[b_we], 500);
    check("t1_lut", we_lut_q[b_we], 15);
    check("t1_st_cnt", st_cnt - b_st, 1);
    check("t1_mult", st_mult_q[b_st], 127);
    check("t1_clr", clr_cnt - b_clr, 1);
    check("t1_fd", fd_cnt - b_fd, 1);
    check("t1_ram", mem[0], 500);
    check("t1_idle", busy, 0);

    // 2: four harmonics, rolloff 10
    for (int i = 0; i < 4; i++) set_mem(8'(i), 16'd0);
    run_frame(16'd1000, 8'd4, 7'd10, "t2_done");
    check("t2_st_cnt", st_cnt - b_st, 4);
    check("t2_we_cnt", we_cnt - b_we, 4);
    for (int i = 0; i < 4; i++) begin
      check("t2_addr", we_addr_q[b_we + i], i);
      check("t2_wdata", we_data_q[b_we + i], 1000 * (i + 1));
      check("t2_mult", st_mult_q[b_st + i], 127 - 10 * i);
    end
    check("t2_lut3", we_lut_q[b_we + 3], 125);

    // 2b: amplitude saturates at zero
    run_frame(16'd1000, 8'd4, 7'd50, "t2b_done");
    check("t2b_mult2", st_mult_q[b_st + 2], 27);
    check("t2b_mult3", st_mult_q[b_st + 3], 0);

    // Frequency clamp
    set_mem(8'd0, 16'd0);
    run_frame(16'd60000, 8'd1, 7'd0, "fclamp_done");
    check("fclamp_wdata", we_data_q[b_we], 47999);
    check("fclamp_lut", we_lut_q[b_we], 1499);

    // Harmonic count clamp
    run_frame(16'd100, 8'd200, 7'd1, "cclamp_done");
    check("cclamp_st", st_cnt - b_st, 64);

    // Increment wrap / Nyquist with freq 20000
    for (int i = 0; i < 3; i++) set_mem(8'(i), 16'd0);
    run_frame(16'd20000, 8'd3, 7'd0, "wrap_done");
`ifdef NYQUIST_CUTOFF_EN
    check("wrap_st_nyq", st_cnt - b_st, 1);
    check("wrap_we_nyq", we_cnt - b_we, 1);
`else
    check("wrap_st", st_cnt - b_st, 3);
    check("wrap_wdata1", we_data_q[b_we + 1], 40000);
    check("wrap_wdata2", we_data_q[b_we + 2], 12000);
`endif

    // 3: accumulator stall
    set_mem(8'd0, 16'd0);
    frequency = 16'd1000;
    harmonic_count = 8'd1;
    rolloff = 7'd0;
    adder_ready = 1'b0;
    snap();
    tick_pulse();
    cyc(28);
    check("t3_no_start", st_cnt - b_st, 0);
    check("t3_busy", busy, 1);
    adder_ready = 1'b1;
    wait_done("t3_done");
    check("t3_st_cnt", st_cnt - b_st, 1);
    check("t3_fd", fd_cnt - b_fd, 1);

    // 4a: tick while busy
    for (int i = 0; i < 2; i++) set_mem(8'(i), 16'd0);
    frequency = 16'd1000;
    harmonic_count = 8'd2;
    snap();
    tick_pulse();
    cyc(3);
    tick_pulse();
    wait_done("t4a_done");
    check("t4a_ov", ov_cnt - b_ov, 1);
    check("t4a_clr", clr_cnt - b_clr, 1);
    check("t4a_st", st_cnt - b_st, 2);
    check("t4a_wdata1", we_data_q[b_we + 1], 2000);

    // 4b: tick in the DONE cycle
    harmonic_count = 8'd1;
    snap();
    tick_pulse();
    n = 0;
    while (!frame_done && n < 200) begin
      cyc(1);
      n++;
    end
    check("t4b_reach_done", frame_done, 1);
    sample_tick = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
    cyc(4);
    check("t4b_ov", ov_cnt - b_ov, 1);
    check("t4b_clr", clr_cnt - b_clr, 1);
    check("t4b_idle", busy, 0);

    // 4c: zero harmonics
    run_frame(16'd1000, 8'd0, 7'd0, "t4c_done");
    check("t4c_clr", clr_cnt - b_clr, 1);
    check("t4c_we", we_cnt - b_we, 0);
    check("t4c_st", st_cnt - b_st, 0);
    check("t4c_fd", fd_cnt - b_fd, 1);

    // 5: reset during LUTW of harmonic 2
    for (int i = 0; i < 4; i++) set_mem(8'(i), 16'd0);
    frequency = 16'd1000;
    harmonic_count = 8'd4;
    rolloff = 7'd0;
    tick_pulse();
    n = 0;
    while (!(pr_we && pr_addr == 8'd2) && n < 200) begin
      cyc(1);
      n++;
    end
    check("t5_reach_h2", {pr_we, pr_addr}, {1'b1, 8'd2});
    cyc(1);
    reset = 1'b1;
    #1;
    check("t5_busy", busy, 0);
    check("t5_outs", {pr_addr, pr_we, adder_mult, adder_start, frame_done}, 0);
    cyc(1);
    reset = 1'b0;
    cyc(1);
    check("t5_ram2", mem[2], 3000);
    check("t5_ram3", mem[3], 0);
    run_frame(16'd1000, 8'd1, 7'd0, "t5_restart_done");
    check("t5_restart_addr", we_addr_q[b_we], 0);
    check("t5_restart_wdata", we_data_q[b_we], 2000);

    // 6: Nyquist cutoff, freq 5000, 10 harmonics
    for (int i = 0; i < 10; i++) set_mem(8'(i), 16'd0);
    run_frame(16'd5000, 8'd10, 7'd0, "t6_done");
`ifdef NYQUIST_CUTOFF_EN
    check("t6_st_nyq", st_cnt - b_st, 4);
    check("t6_we_nyq", we_cnt - b_we, 4);
`else
    check("t6_st", st_cnt - b_st, 10);
    check("t6_we", we_cnt - b_we, 10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
